// File: rtl/cpu_pkg.sv
// Shared execute-stage definitions: mul/div op codes, register-file
// write destinations and the mul/div sequencer states.
package cpu_pkg;

    localparam logic [1:0] MD_MULTU = 2'b00;
    localparam logic [1:0] MD_DIVU  = 2'b01;
    localparam logic [1:0] MD_MULT  = 2'b10;
    localparam logic [1:0] MD_DIV   = 2'b11;

    localparam logic [1:0] W_DEST_NONE = 2'b00;
    localparam logic [1:0] W_DEST_RS   = 2'b01;
    localparam logic [1:0] W_DEST_RT   = 2'b10;
    localparam logic [1:0] W_DEST_R31  = 2'b11;

    typedef enum logic [1:0] {
        MD_IDLE,
        MD_RUN,
        MD_FIXUP,
        MD_DONE
    } md_state;

endpackage

// File: rtl/mul_div_unit_md_step.sv
// One iteration of the shared multiply/divide datapath on a {hi,lo}
// accumulator: shift-add multiply or restoring shift-subtract divide.
module md_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0]   operand_i,
    input  logic               div_i,
    output logic [2*WIDTH-1:0] acc_o,
    output logic               q_bit_o
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] diff;

    always_comb begin
        sum = {1'b0, acc_i[2*WIDTH-1:WIDTH]}
            + {1'b0, (acc_i[0] ? operand_i : {WIDTH{1'b0}})};
        rem_sh = acc_i[2*WIDTH-1:WIDTH-1];
        diff = rem_sh - {1'b0, operand_i};
        q_bit_o = 1'b0;
        acc_o = {sum, acc_i[WIDTH-1:1]};
        if (div_i) begin
            // Top bit of the trial difference is its sign.
            q_bit_o = ~diff[WIDTH];
            acc_o = {(diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0]),
                     acc_i[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit for the execute stage.
// Signed MULT/DIV (ops 10/11) are built only with SIGNED_OPS_EN defined.
module mul_div_unit
    import cpu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       dest_sel,
    output logic             busy,
    output logic             done,
    output logic [1:0]       w_dest,
    output logic [WIDTH-1:0] reg_write_data,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    localparam int W2 = 2 * WIDTH;

    md_state          state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [W2-1:0]    acc_q;
    logic [WIDTH-1:0] opnd_q, a_orig_q, hi_q, lo_q;
    logic             is_div_q, bzero_q, done_q, dbz_q;
    logic [1:0]       dest_q, wdest_q;

    logic [W2-1:0]    step_acc, run_d, res_d;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic             step_q, accept, last, to_fix, fin;

`ifdef SIGNED_OPS_EN
    logic          sgn_q, neg_q, a_neg_q;
    logic [W2-1:0] fix_d;
`endif

    md_step #(.WIDTH(WIDTH)) u_step (
        .acc_i     (acc_q),
        .operand_i (opnd_q),
        .div_i     (is_div_q),
        .acc_o     (step_acc),
        .q_bit_o   (step_q)
    );

    assign run_d = {step_acc[W2-1:1], step_acc[0] | step_q};
    assign busy  = (state_q == MD_RUN) || (state_q == MD_FIXUP);
    assign last  = (cnt_q == CNT_W'(WIDTH - 1));

`ifdef SIGNED_OPS_EN
    assign accept = start && !busy;
    assign to_fix = sgn_q;

    // Operands are iterated as magnitudes; signs are restored in FIXUP.
    always_comb begin
        a_mag = a;
        b_mag = b;
        if (op[1] && a[WIDTH-1]) a_mag = -a;
        if (op[1] && b[WIDTH-1]) b_mag = -b;
    end

    always_comb begin
        fix_d = acc_q;
        if (!is_div_q && neg_q) fix_d = -acc_q;
        if (is_div_q) begin
            if (neg_q)   fix_d[WIDTH-1:0]  = -acc_q[WIDTH-1:0];
            if (a_neg_q) fix_d[W2-1:WIDTH] = -acc_q[W2-1:WIDTH];
        end
    end
`else
    assign accept = start && !busy && !op[1];
    assign to_fix = 1'b0;
    assign a_mag  = a;
    assign b_mag  = b;
`endif

    assign fin = ((state_q == MD_RUN) && last && !to_fix)
              || (state_q == MD_FIXUP);

    always_comb begin
        res_d = run_d;
`ifdef SIGNED_OPS_EN
        if (state_q == MD_FIXUP) res_d = fix_d;
`endif
        if (is_div_q && bzero_q) res_d = {a_orig_q, {WIDTH{1'b1}}};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= MD_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            a_orig_q <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            is_div_q <= 1'b0;
            bzero_q  <= 1'b0;
            dest_q   <= W_DEST_NONE;
            wdest_q  <= W_DEST_NONE;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
`ifdef SIGNED_OPS_EN
            sgn_q    <= 1'b0;
            neg_q    <= 1'b0;
            a_neg_q  <= 1'b0;
`endif
        end else begin
            done_q  <= 1'b0;
            wdest_q <= W_DEST_NONE;
            dbz_q   <= 1'b0;
            unique case (state_q)
                MD_IDLE, MD_DONE: begin
                    if (accept) begin
                        state_q  <= MD_RUN;
                        cnt_q    <= '0;
                        acc_q    <= {{WIDTH{1'b0}}, a_mag};
                        opnd_q   <= b_mag;
                        a_orig_q <= a;
                        is_div_q <= (op == MD_DIVU) || (op == MD_DIV);
                        bzero_q  <= (b == '0);
                        dest_q   <= dest_sel;
`ifdef SIGNED_OPS_EN
                        sgn_q    <= op[1];
                        neg_q    <= op[1] && (a[WIDTH-1] ^ b[WIDTH-1]);
                        a_neg_q  <= op[1] && a[WIDTH-1];
`endif
                    end else begin
                        state_q <= MD_IDLE;
                    end
                end
                MD_RUN: begin
                    acc_q <= run_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (last) state_q <= to_fix ? MD_FIXUP : MD_DONE;
                end
                MD_FIXUP: state_q <= MD_DONE;
            endcase
            if (fin) begin
                hi_q    <= res_d[W2-1:WIDTH];
                lo_q    <= res_d[WIDTH-1:0];
                done_q  <= 1'b1;
                wdest_q <= dest_q;
                dbz_q   <= is_div_q && bzero_q;
            end
        end
    end

    assign done           = done_q;
    assign w_dest         = wdest_q;
    assign reg_write_data = lo_q;
    assign hi             = hi_q;
    assign lo             = lo_q;
    assign div_by_zero    = dbz_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed cases plus a random
// sweep against an arithmetic reference model.
module tb_mul_div_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [1:0]  dest_sel = 2'b00;
    logic        busy, done, div_by_zero;
    logic [1:0]  w_dest;
    logic [31:0] reg_write_data, hi, lo;

    int checks = 0;
    int errors = 0;

    mul_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .op             (op),
        .a              (a),
        .b              (b),
        .dest_sel       (dest_sel),
        .busy           (busy),
        .done           (done),
        .w_dest         (w_dest),
        .reg_write_data (reg_write_data),
        .hi             (hi),
        .lo             (lo),
        .div_by_zero    (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: {hi,lo} from plain arithmetic on the operation's meaning.
    function automatic logic [63:0] model(input logic [1:0] o,
                                          input logic [31:0] x,
                                          input logic [31:0] y);
        longint sx, sy;
        logic [63:0] q, r;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (o)
            2'b00: return {32'b0, x} * {32'b0, y};
            2'b01: begin
                if (y == 0) return {x, 32'hFFFF_FFFF};
                return {x % y, x / y};
            end
            2'b10: return 64'(sx * sy);
            default: begin
                if (y == 0) return {x, 32'hFFFF_FFFF};
                q = 64'(sx / sy);
                r = 64'(sx % sy);
                return {r[31:0], q[31:0]};
            end
        endcase
    endfunction

    // Count edges until done is seen (bounded), tracking stray writes.
    task automatic wait_done(input int n0, output int n, output int spur);
        n = n0;
        spur = 0;
        while (!done && n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (!done && w_dest != 2'b00) spur++;
            a = $urandom;
            b = $urandom;
        end
    endtask

    task automatic do_op(input string tag, input logic [1:0] o,
                         input logic [31:0] x, input logic [31:0] y,
                         input logic [1:0] d);
        int n, spur, lat;
        logic [63:0] exp;
        exp = model(o, x, y);
        lat = o[1] ? 33 : 32;
        @(negedge clk);
        start = 1'b1;
        op = o;
        a = x;
        b = y;
        dest_sel = d;
        @(posedge clk);
        #1;
        start = 1'b0;
        dest_sel = 2'($urandom);
        chk({tag, "_busy"}, 64'(busy), 64'd1);
        wait_done(0, n, spur);
        chk({tag, "_lat"}, 64'(n), 64'(lat));
        chk({tag, "_spur"}, 64'(spur), 64'd0);
        chk({tag, "_wdest"}, 64'(w_dest), 64'(d));
        chk({tag, "_hilo"}, {hi, lo}, exp);
        chk({tag, "_rwd"}, 64'(reg_write_data), 64'(exp[31:0]));
        chk({tag, "_dbz"}, 64'(div_by_zero), 64'(o[0] && y == 0));
        chk({tag, "_busy0"}, 64'(busy), 64'd0);
        @(posedge clk);
        #1;
        chk({tag, "_post"}, {60'(hi), done, w_dest, div_by_zero},
            {60'(exp[63:32]), 1'b0, 2'b00, 1'b0});
        chk({tag, "_hold"}, {hi, lo}, exp);
    endtask

    initial begin
        int n, spur, dn;
        logic [1:0] ro;
        logic [31:0] ra, rb;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_state", {60'(hi), busy, done, w_dest},
            {60'd0, 1'b0, 1'b0, 2'b00});
        chk("rst_lo_dbz", {lo, 31'd0, div_by_zero}, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        do_op("multu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b10);
        do_op("divu_100_7", 2'b01, 32'd100, 32'd7, 2'b11);
        do_op("divu_zero", 2'b01, 32'h1234_5678, 32'd0, 2'b01);

        // Second start while busy is ignored; start in done cycle accepted.
        @(negedge clk);
        start = 1'b1; op = 2'b00; a = 32'd3; b = 32'd5; dest_sel = 2'b01;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        start = 1'b1; op = 2'b01; a = 32'd1000; b = 32'd3; dest_sel = 2'b10;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(5, n, spur);
        chk("ign_lat", 64'(n), 64'd32);
        chk("ign_res", {hi, lo}, 64'd15);
        chk("ign_wdest", 64'(w_dest), 64'(2'b01));
        start = 1'b1; op = 2'b01; a = 32'd50; b = 32'd5; dest_sel = 2'b11;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("b2b_busy", {busy, done}, 64'(2'b10));
        wait_done(0, n, spur);
        chk("b2b_lat", 64'(n), 64'd32);
        chk("b2b_res", {hi, lo}, 64'd10);
        chk("b2b_wdest", 64'(w_dest), 64'(2'b11));

        // Reset ten cycles into a divide.
        @(negedge clk);
        start = 1'b1; op = 2'b01; a = 32'hDEAD_BEEF; b = 32'd3; dest_sel = 2'b10;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst", {hi, lo}, 64'd0);
        chk("mid_rst_ctl", {busy, done, w_dest}, 64'd0);
        rst = 1'b0;
        dn = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done || w_dest != 2'b00) dn++;
        end
        chk("mid_rst_nodone", 64'(dn), 64'd0);

`ifdef SIGNED_OPS_EN
        do_op("div_m7_2", 2'b11, 32'hFFFF_FFF9, 32'd2, 2'b01);
        do_op("mult_neg", 2'b10, 32'hFFFF_FFFD, 32'd7, 2'b10);
        do_op("div_min_m1", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 2'b11);
        do_op("div_s_zero", 2'b11, 32'hFFFF_FF00, 32'd0, 2'b01);
`else
        @(negedge clk);
        start = 1'b1; op = 2'b11; a = 32'hFFFF_FFF9; b = 32'd2; dest_sel = 2'b01;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("nosign_busy", 64'(busy), 64'd0);
        dn = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done || busy) dn++;
        end
        chk("nosign_nodone", 64'(dn), 64'd0);
`endif

        for (int i = 0; i < 24; i++) begin
`ifdef SIGNED_OPS_EN
            ro = 2'($urandom_range(0, 3));
`else
            ro = 2'($urandom_range(0, 1));
`endif
            ra = $urandom;
            rb = $urandom;
            if (i % 6 == 0) rb = 32'd0;
            if (i % 6 == 1) rb = 32'($urandom_range(1, 300));
            if (i % 6 == 2) ra = 32'($urandom_range(0, 50));
            do_op($sformatf("rnd%0d", i), ro, ra, rb, 2'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
